sound_generator: RTL and testbench
==================================

SOUND_GENERATOR -- requirements
Module: sound_generator

Interface
REQ-001 SHALL have parameter HIT_HALF, default 25000, speaker half-period in clk cycles for the hit tone (500 Hz at 25 MHz).
REQ-002 SHALL have parameter WALL_HALF, default 50000, half-period for the wall tone.
REQ-003 SHALL have parameter GOAL_HALF, default 100000, half-period for the goal tone.
REQ-004 SHALL have parameters HIT_LEN 2500000, WALL_LEN 1250000, GOAL_LEN 7500000 and NOTE_LEN 5000000, tone or note durations in clk cycles.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have ports hit, wall and goal, input, 1 bit each, single-cycle event pulses from the game controller.
REQ-008 SHALL have ports p1_win and p2_win, input, 1 bit each, level win flags.
REQ-009 SHALL have port mute, input, 1 bit; when high it forces spk low and the sequencer keeps running.
REQ-010 SHALL have port spk, output, 1 bit, square-wave speaker drive.
REQ-011 SHALL have port busy, output, 1 bit, high while any tone or melody is active.
REQ-012 SHALL have port tone_id, output, 3 bits, encoded 0 = none, 1 = wall, 2 = hit, 3 = goal, 4 = win.

Function
REQ-013 SHALL implement the FSM states IDLE, TONE and MELODY.
REQ-014 SHALL assign event priority win > goal > hit > wall; among simultaneous same-cycle events, only the highest-priority one is accepted.
REQ-015 SHALL detect a win event as a rising edge of (p1_win | p2_win), using a one-cycle registered copy.
REQ-016 SHALL, on an accepted event in IDLE, enter TONE (or MELODY for win) on the next edge, with busy = 1, tone_id set, the half-period counter at 0 and the duration counter at 0.
REQ-017 SHALL, when an event arrives while busy with priority >= the current tone, restart the tone at the new event; a lower-priority event is dropped.
REQ-018 SHALL toggle spk each time the half-period counter reaches (half - 1), then clear that counter; the first toggle occurs `half` cycles after entry and spk starts at 0.
REQ-019 SHALL, in TONE, return to IDLE when the duration counter reaches (LEN - 1), driving spk = 0, busy = 0 and tone_id = 0 on that transition edge.
REQ-020 SHALL, in MELODY, play 4 notes of NOTE_LEN cycles each, using half-periods from a package table indexed by a 2-bit note index.
REQ-021 SHALL, in MELODY, reset spk to 0 at each note boundary, then return to IDLE after note 3.
REQ-022 SHALL size counter widths as $clog2 of the largest parameter; no counter may wrap before its terminal count.
REQ-023 SHALL apply mute only at the output: spk = spk_int & ~mute; busy and tone_id are unaffected by mute.
REQ-024 SHALL keep a held p1_win level from retriggering; a new melody requires the win flags to fall and then rise again.
REQ-025 SHALL drive all outputs from registers, with no combinational path from inputs to spk, busy or tone_id except the mute AND.

Reset
REQ-026 SHALL, with rst high at a clk edge, set state IDLE, spk = 0, busy = 0, tone_id = 0, all counters 0, note index 0 and the win-edge register 0.
REQ-027 SHALL, on reset mid-tone or mid-melody, silence immediately at the next edge; events present during reset are ignored.

Structure
REQ-028 SHALL define the FSM state encoding, the tone_id codes and the 4-entry melody half-period table (47800, 37900, 31900, 23900) in the shared package game_pkg.
REQ-029 SHALL place the half-period counter and toggle flop in one sub-module, square_wave, with ports clk, rst, restart, half and wave.

Verification
REQ-030 SHALL verify, with HIT_HALF = 2 and HIT_LEN = 10: a hit pulse makes spk toggle every 2 cycles, busy stays high for 10 cycles, then tone_id returns to 0.
REQ-031 SHALL verify that hit and wall pulsed in the same cycle give tone_id = 2, and a wall pulse during that hit tone leaves tone_id = 2.
REQ-032 SHALL verify that a goal pulse 3 cycles into a hit tone gives tone_id = 3 with the duration counter restarted, so busy lasts a full GOAL_LEN.
REQ-033 SHALL verify, with NOTE_LEN = 8: raising p2_win gives 32 busy cycles with tone_id = 4; holding p2_win high gives no second melody.
REQ-034 SHALL verify that mute = 1 during a goal tone holds spk at 0 while busy = 1, and spk resumes toggling when mute is released.
REQ-035 SHALL verify that rst asserted for 1 cycle mid-melody gives spk = 0, busy = 0 and tone_id = 0 on the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game sound path: FSM states, tone codes and
// the victory melody half-period table.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TONE   = 2'd1,
        MELODY = 2'd2
    } state_t;

    // Codes double as priority levels: a larger code wins.
    typedef enum logic [2:0] {
        TONE_NONE = 3'd0,
        TONE_WALL = 3'd1,
        TONE_HIT  = 3'd2,
        TONE_GOAL = 3'd3,
        TONE_WIN  = 3'd4
    } tone_t;

    localparam int unsigned MEL_MAX = 47800;

    function automatic logic [15:0] melody_half(input logic [1:0] idx);
        case (idx)
            2'd0:    return 16'd47800;
            2'd1:    return 16'd37900;
            2'd2:    return 16'd31900;
            default: return 16'd23900;
        endcase
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/square_wave.sv
// Half-period counter and toggle flop; restart clears both so every tone
// or note begins low with a full half-period before the first edge.
module square_wave #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] half,
    output logic         wave
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == half - 1'b1) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sound_generator.sv
// Game sound sequencer: prioritised event tones plus a four-note win melody,
// square-wave speaker output with an output-only mute.
module sound_generator
    import game_pkg::*;
#(
    parameter int unsigned HIT_HALF  = 25000,
    parameter int unsigned WALL_HALF = 50000,
    parameter int unsigned GOAL_HALF = 100000,
    parameter int unsigned HIT_LEN   = 2500000,
    parameter int unsigned WALL_LEN  = 1250000,
    parameter int unsigned GOAL_LEN  = 7500000,
    parameter int unsigned NOTE_LEN  = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       wall,
    input  logic       goal,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       mute,
    output logic       spk,
    output logic       busy,
    output logic [2:0] tone_id
);

    localparam int unsigned MAXP = max2(
        max2(max2(HIT_HALF, WALL_HALF), max2(GOAL_HALF, MEL_MAX)),
        max2(max2(HIT_LEN, WALL_LEN), max2(GOAL_LEN, NOTE_LEN)));
    localparam int unsigned W = $clog2(MAXP + 1);

    localparam logic [W-1:0] HIT_H  = W'(HIT_HALF);
    localparam logic [W-1:0] WALL_H = W'(WALL_HALF);
    localparam logic [W-1:0] GOAL_H = W'(GOAL_HALF);
    localparam logic [W-1:0] HIT_L  = W'(HIT_LEN);
    localparam logic [W-1:0] WALL_L = W'(WALL_LEN);
    localparam logic [W-1:0] GOAL_L = W'(GOAL_LEN);
    localparam logic [W-1:0] NOTE_L = W'(NOTE_LEN);

    state_t       state, state_n;
    tone_t        tone_q, tone_n, ev;
    logic [W-1:0] dur, dur_n;
    logic [1:0]   note, note_n;
    logic         win_q, win_rise, accept, restart, wave;
    logic [W-1:0] cur_half, cur_len;

    assign win_rise = (p1_win | p2_win) & ~win_q;

    always_comb begin
        if (win_rise)  ev = TONE_WIN;
        else if (goal) ev = TONE_GOAL;
        else if (hit)  ev = TONE_HIT;
        else if (wall) ev = TONE_WALL;
        else           ev = TONE_NONE;
    end

    // Equal priority restarts the current tone; idle tone_q is NONE so any event wins.
    assign accept = (ev != TONE_NONE) && (ev >= tone_q);

    always_comb begin
        case (tone_q)
            TONE_WALL: begin cur_half = WALL_H; cur_len = WALL_L; end
            TONE_HIT:  begin cur_half = HIT_H;  cur_len = HIT_L;  end
            TONE_GOAL: begin cur_half = GOAL_H; cur_len = GOAL_L; end
            default:   begin cur_half = W'(melody_half(note)); cur_len = NOTE_L; end
        endcase
    end

    always_comb begin
        state_n = state;
        tone_n  = tone_q;
        dur_n   = dur + 1'b1;
        note_n  = note;
        restart = 1'b0;
        case (state)
            TONE: begin
                if (dur == cur_len - 1'b1) begin
                    state_n = IDLE;
                    tone_n  = TONE_NONE;
                    dur_n   = '0;
                    restart = 1'b1;
                end
            end
            MELODY: begin
                if (dur == cur_len - 1'b1) begin
                    dur_n   = '0;
                    restart = 1'b1;
                    if (note == 2'd3) begin
                        state_n = IDLE;
                        tone_n  = TONE_NONE;
                        note_n  = 2'd0;
                    end else begin
                        note_n = note + 1'b1;
                    end
                end
            end
            default: begin
                dur_n   = '0;
                restart = 1'b1;
            end
        endcase
        if (accept) begin
            state_n = (ev == TONE_WIN) ? MELODY : TONE;
            tone_n  = ev;
            dur_n   = '0;
            note_n  = 2'd0;
            restart = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tone_q <= TONE_NONE;
            dur    <= '0;
            note   <= 2'd0;
            win_q  <= 1'b0;
        end else begin
            state  <= state_n;
            tone_q <= tone_n;
            dur    <= dur_n;
            note   <= note_n;
            win_q  <= p1_win | p2_win;
        end
    end

    square_wave #(.W(W)) u_wave (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .half    (cur_half),
        .wave    (wave)
    );

    assign spk     = wave & ~mute;
    assign busy    = (state != IDLE);
    assign tone_id = tone_q;

endmodule

// File: tb/tb_sound_generator.sv
// Directed bench for sound_generator with shortened tone and note lengths.
module tb_sound_generator;

    logic       clk = 1'b0;
    logic       rst, hit, wall, goal, p1_win, p2_win, mute;
    logic       spk, busy;
    logic [2:0] tone_id;

    int total = 0;
    int bad   = 0;
    int n;

    sound_generator #(
        .HIT_HALF  (2),
        .WALL_HALF (3),
        .GOAL_HALF (4),
        .HIT_LEN   (10),
        .WALL_LEN  (6),
        .GOAL_LEN  (12),
        .NOTE_LEN  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hit     (hit),
        .wall    (wall),
        .goal    (goal),
        .p1_win  (p1_win),
        .p2_win  (p2_win),
        .mute    (mute),
        .spk     (spk),
        .busy    (busy),
        .tone_id (tone_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Counts cycles with busy high, starting at the current sample point.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; hit = 0; wall = 0; goal = 0; p1_win = 0; p2_win = 0; mute = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_tone", tone_id, 0);
        chk("rst_spk", spk, 0);
        rst = 1'b0;
        tick();

        // Hit tone: half 2, length 10
        hit = 1; tick(); hit = 0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("hit_spk_%0d", k), spk, (k / 2) % 2);
            chk($sformatf("hit_busy_%0d", k), busy, 1);
            chk($sformatf("hit_tone_%0d", k), tone_id, 2);
            tick();
        end
        chk("hit_end_busy", busy, 0);
        chk("hit_end_tone", tone_id, 0);
        chk("hit_end_spk", spk, 0);
        tick();

        // Wall alone: length 6
        wall = 1; tick(); wall = 0;
        chk("wall_tone", tone_id, 1);
        count_busy(n);
        chk("wall_len", n, 6);
        tick();

        // Simultaneous hit+wall, then a lower-priority wall mid-tone
        hit = 1; wall = 1; tick(); hit = 0; wall = 0;
        chk("hitwall_tone", tone_id, 2);
        tick(); tick();
        wall = 1; tick(); wall = 0;
        chk("wall_drop_tone", tone_id, 2);
        count_busy(n);
        chk("wall_drop_len", n, 7);
        tick();

        // Goal 3 cycles into a hit restarts duration
        hit = 1; tick(); hit = 0;
        tick(); tick(); tick();
        goal = 1; tick(); goal = 0;
        chk("goal_tone", tone_id, 3);
        count_busy(n);
        chk("goal_len", n, 12);
        tick();

        // Win melody: 4 notes of 8
        p2_win = 1; tick();
        chk("win_tone", tone_id, 4);
        count_busy(n);
        chk("win_len", n, 32);
        chk("win_end_tone", tone_id, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("win_hold_busy", busy, 0);
        p2_win = 0; tick();

        // Mute during goal tone (half 4)
        goal = 1; tick(); goal = 0;
        mute = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("mute_spk_%0d", k), spk, 0);
            chk($sformatf("mute_busy_%0d", k), busy, 1);
        end
        mute = 0; #1;
        chk("unmute_spk_6", spk, 1);
        tick();
        chk("unmute_spk_7", spk, 1);
        tick();
        chk("unmute_spk_8", spk, 0);
        count_busy(n);
        chk("mute_rest_len", n, 4);
        tick();

        // Reset mid-hit while spk is high
        hit = 1; tick(); hit = 0;
        tick(); tick();
        chk("pre_rst_spk", spk, 1);
        rst = 1; tick(); rst = 0;
        chk("rsthit_spk", spk, 0);
        chk("rsthit_busy", busy, 0);
        chk("rsthit_tone", tone_id, 0);
        tick();

        // Reset mid-melody
        p1_win = 1; tick();
        chk("p1_tone", tone_id, 4);
        for (int k = 0; k < 10; k++) tick();
        chk("p1_mid_busy", busy, 1);
        rst = 1; p1_win = 0; tick(); rst = 0;
        chk("rstmel_spk", spk, 0);
        chk("rstmel_busy", busy, 0);
        chk("rstmel_tone", tone_id, 0);
        tick();
        chk("rstmel_after_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
